// File: rtl/mul_sequencer_pkg.sv
// Shared types and RV32M encoding constants for the iterative multiplier.
// Decode uses FUNCT7_MULDIV/FUNCT3_MUL (via is_mul) to raise the multiplier start request.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [2:0] FUNCT3_MUL    = 3'b000;

  function automatic logic is_mul(input logic [6:0] opcode,
                                  input logic [6:0] funct7,
                                  input logic [2:0] funct3);
    return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV) && (funct3 == FUNCT3_MUL);
  endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Request/response bundle between the EX stage and the multiplier.
// The pipeline side drives through master; the multiplier receives it through slave.
interface mul_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              flush;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              busy;
  logic              stall;

  modport master (
    output start, flush, op_a, op_b,
    input  result, result_valid, busy, stall
  );

  modport slave (
    input  start, flush, op_a, op_b,
    output result, result_valid, busy, stall
  );
endinterface

// File: rtl/mul_shift_add_dp.sv
// Shift-add datapath: accumulator, shifting multiplicand/multiplier and iteration count.
// o_mplier_zero looks one step ahead so the controller can end RUN on the final useful iteration.
module mul_shift_add_dp
  import mul_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  output logic [DATA_W-1:0] o_acc,
  output logic              o_mplier_zero,
  output logic              o_last
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_addend;

  assign w_addend = r_mplier[0] ? r_mcand : '0;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_clear) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= i_op_a;
      r_mplier <= i_op_b;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_acc    <= r_acc + w_addend;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  assign o_acc         = r_acc;
  assign o_mplier_zero = (r_mplier[DATA_W-1:1] == '0);
  assign o_last        = (r_cnt == LAST_CNT);

endmodule

// File: rtl/mul_sequencer.sv
// RV32M MUL sequencer: FSM, pipeline stall and result presentation around the shift-add datapath.
// Define MUL_EARLY_TERM_EN to end RUN as soon as the remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | waiting for start; result holds the last product
// RUN   | one shift-add iteration per cycle, pipeline stalled
// DONE  | product presented for one cycle, pipeline released
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           arst_n,
  mul_sequencer_if.slave bus
);

  mul_state_t        r_state;
  mul_state_t        w_state_nxt;
  logic              w_load;
  logic              w_step;
  logic              w_clear;
  logic              w_run_end;
  logic              w_last;
  logic              w_mplier_zero;
  logic [DATA_W-1:0] w_acc;
  logic [DATA_W-1:0] r_result;

  mul_shift_add_dp #(
    .DATA_W (DATA_W)
  ) u_dp (
    .clk           (clk),
    .arst_n        (arst_n),
    .i_load        (w_load),
    .i_step        (w_step),
    .i_clear       (w_clear),
    .i_op_a        (bus.op_a),
    .i_op_b        (bus.op_b),
    .o_acc         (w_acc),
    .o_mplier_zero (w_mplier_zero),
    .o_last        (w_last)
  );

`ifdef MUL_EARLY_TERM_EN
  assign w_run_end = w_last || w_mplier_zero;
`else
  logic w_unused_mplier_zero;
  assign w_unused_mplier_zero = w_mplier_zero;
  assign w_run_end            = w_last;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.flush) begin
          w_clear     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_step = 1'b1;
          if (w_run_end) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // A flushed DONE is not a completion, so the held product stays the previous one.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_result <= '0;
    end else if ((r_state == DONE) && !bus.flush) begin
      r_result <= w_acc;
    end
  end

  assign bus.result       = (r_state == DONE) ? w_acc : r_result;
  assign bus.result_valid = (r_state == DONE) && !bus.flush;
  assign bus.busy         = (r_state != IDLE);
  assign bus.stall        = arst_n &&
                            (((r_state == IDLE) && bus.start && !bus.flush) ||
                             ((r_state == RUN) && !bus.flush));

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: driver pushes expected product and completion cycle,
// a negedge monitor pops and compares whenever result_valid is seen.
module tb_mul_sequencer;

  localparam int DW = 32;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;

  mul_sequencer_if #(.DATA_W(DW)) bus();

  mul_sequencer #(.DATA_W(DW)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] prod;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] held   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference latency: number of RUN cycles from the multiplier value alone.
  function automatic int run_len(input logic [31:0] b);
    int n;
    n = DW;
`ifdef MUL_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < DW; i++) if (b[i]) n = i + 1;
`endif
    return n;
  endfunction

  always @(negedge clk) begin
    if (arst_n) begin
      if (bus.result_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got result %h with no pending op (cycle %0d)", bus.result, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result", bus.result, mon_e.prod);
          chk("valid_cycle", cyc, mon_e.cyc);
          chk("stall_on_valid", {31'b0, bus.stall}, 32'd0);
          held = mon_e.prod;
        end
      end else if (!bus.busy) begin
        chk("result_hold", bus.result, held);
      end
    end
  end

  task automatic step_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called and returns at 1 time unit after a rising edge.
  // flush_at: -1 none, 0 with start, k>0 in cycle k after start (L+1 is DONE).
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input bit spur);
    int   c0;
    int   len;
    bit   sp;
    exp_t e;
    len = run_len(b);
    sp  = spur && (flush_at < 0) && (len >= 3);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    c0        = cyc;
    if (flush_at == 0) begin
      bus.flush = 1'b1;
      #1 chk("stall_start_flush", {31'b0, bus.stall}, 32'd0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      chk("busy_after_idle_flush", {31'b0, bus.busy}, 32'd0);
      return;
    end
    if (flush_at < 0) begin
      e.prod = a * b;
      e.cyc  = c0 + len + 1;
      exp_q.push_back(e);
    end
    #1 chk("stall_start", {31'b0, bus.stall}, 32'd1);
    for (int k = 1; k <= len + 1; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        bus.start = 1'b0;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
      end
      if (sp && k == 2) begin
        bus.start = 1'b1;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
      end
      if (sp && k == 3) bus.start = 1'b0;
      if (k == flush_at) begin
        bus.flush = 1'b1;
        #1 chk("stall_flush", {31'b0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("busy_after_flush", {31'b0, bus.busy}, 32'd0);
        return;
      end
      #1;
      if (k <= len) begin
        chk("stall_run", {31'b0, bus.stall}, 32'd1);
      end else begin
        chk("stall_done", {31'b0, bus.stall}, 32'd0);
        chk("busy_done", {31'b0, bus.busy}, 32'd1);
      end
    end
    @(posedge clk);
    #1;
    chk("busy_idle", {31'b0, bus.busy}, 32'd0);
  endtask

  task automatic reset_mid_run(input logic [31:0] a, input logic [31:0] b);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    step_cycles(5);
    #2;
    bus.start = 1'b1;
    arst_n    = 1'b0;
    held      = '0;
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_valid", {31'b0, bus.result_valid}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_stall", {31'b0, bus.stall}, 32'd0);
    #2;
    bus.start = 1'b0;
    arst_n    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d ops pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int          r;
    int          fa;
    logic [31:0] a;
    logic [31:0] b;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    #1;
    chk("init_busy", {31'b0, bus.busy}, 32'd0);
    chk("init_valid", {31'b0, bus.result_valid}, 32'd0);
    chk("init_result", bus.result, 32'd0);
    chk("init_stall", {31'b0, bus.stall}, 32'd0);
    #11 arst_n = 1'b1;
    @(posedge clk);
    #1;

    do_mul(32'd7, 32'd6, -1, 1'b0);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    do_mul(32'h8000_0000, 32'd2, -1, 1'b0);
    do_mul(32'd12345, 32'h00AB_CDEF, 10, 1'b0);
    do_mul(32'd3, 32'd4, -1, 1'b0);
    reset_mid_run(32'h1234, 32'h8000_0001);
    do_mul(32'd5, 32'd5, -1, 1'b0);
    do_mul(32'd9, 32'd5, -1, 1'b0);
    do_mul(32'hDEAD, 32'd0, -1, 1'b0);
    do_mul(32'd11, 32'd13, -1, 1'b1);
    do_mul(32'd77, 32'd88, 0, 1'b0);
    do_mul(32'd100, 32'd200, run_len(32'd200) + 1, 1'b0);
    do_mul(32'd21, 32'd2, -1, 1'b0);

    for (int i = 0; i < 25; i++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      r  = $urandom_range(0, 9);
      fa = -1;
      if (r == 0) fa = $urandom_range(1, run_len(b) + 1);
      if (r == 1) fa = 0;
      do_mul(a, b, fa, (r == 2));
      step_cycles($urandom_range(0, 2));
    end

    for (int t = 0; t < 50 && exp_q.size() != 0; t++) step_cycles(1);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending ops expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
